// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } arb_state_t;

  typedef enum logic {
    PORT_C,
    PORT_E
  } port_sel_t;

  localparam int CNT_W = 4;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: a lone requester wins outright; on contention
// the port that was not granted last time wins.
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  port_sel_t  last_grant,
  output logic       valid,
  output port_sel_t  grant
);

  always_comb begin
    valid = |req;
    grant = PORT_C;
    if (req == 2'b10) begin
      grant = PORT_E;
    end else if (req == 2'b11) begin
      grant = (last_grant == PORT_C) ? PORT_E : PORT_C;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port memory between the CPU (port C) and an
// external loader/debug port (port E), one transaction at a time.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_ack,
  output logic [DW-1:0] c_rdata,
  input  logic          e_req,
  input  logic          e_we,
  input  logic [AW-1:0] e_addr,
  input  logic [DW-1:0] e_wdata,
  output logic          e_ack,
  output logic [DW-1:0] e_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_lat_check
    $error("mem_port_arbiter: MEM_LAT must lie in 1..15");
  end

  arb_state_t           state_q, state_d;
  port_sel_t            last_grant_q, last_grant_d;
  port_sel_t            grant_q, grant_d;
  logic                 we_q, we_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic [DW-1:0]        wdata_q, wdata_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DW-1:0]        c_rdata_q, c_rdata_d;
  logic [DW-1:0]        e_rdata_q, e_rdata_d;

  logic                 pick_valid;
  port_sel_t            pick_grant;

  rr_pick2 u_pick (
    .req        ({e_req, c_req}),
    .last_grant (last_grant_q),
    .valid      (pick_valid),
    .grant      (pick_grant)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its peers; blocking here would create order races.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= PORT_E;
      grant_q      <= PORT_C;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      c_rdata_q    <= '0;
      e_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      c_rdata_q    <= c_rdata_d;
      e_rdata_q    <= e_rdata_d;
    end
  end

  // NOTE: every next-state signal takes its hold value first so no path
  // through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    c_rdata_d    = c_rdata_q;
    e_rdata_d    = e_rdata_q;

    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_d      = pick_grant;
          last_grant_d = pick_grant;
          if (pick_grant == PORT_C) begin
            we_d    = c_we;
            addr_d  = c_addr;
            wdata_d = c_wdata;
          end else begin
            we_d    = e_we;
            addr_d  = e_addr;
            wdata_d = e_wdata;
          end
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (we_q) begin
          state_d = DONE;
        end else begin
          cnt_d   = CNT_W'(MEM_LAT - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          if (grant_q == PORT_C) c_rdata_d = mem_rdata;
          else                   e_rdata_d = mem_rdata;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Memory strobes decode straight from the state register so they fall with
  // reset asynchronously and stay all-zero outside the ISSUE cycle.
  assign mem_en    = (state_q == ISSUE);
  assign mem_we    = mem_en & we_q;
  assign mem_addr  = mem_en ? addr_q : '0;
  assign mem_wdata = mem_en ? wdata_q : '0;

  assign c_ack   = (state_q == DONE) && (grant_q == PORT_C);
  assign e_ack   = (state_q == DONE) && (grant_q == PORT_E);
  assign c_rdata = c_rdata_q;
  assign e_rdata = e_rdata_q;
  assign busy    = (state_q != IDLE);

  a_ack_exclusive: assert property (@(posedge clk) disable iff (reset)
    !(c_ack && e_ack));
  a_en_single: assert property (@(posedge clk) disable iff (reset)
    mem_en |=> !mem_en);
  a_grant_issues: assert property (@(posedge clk) disable iff (reset)
    (state_q == IDLE && pick_valid) |=> mem_en);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scoreboard bench for mem_port_arbiter at MEM_LAT = 2, 1 and 15.
module tb_mem_port_arbiter;

  localparam int N = 3;

  typedef struct {
    logic        port;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic [N-1:0]       c_req, c_we, e_req, e_we;
  logic [N-1:0][31:0] c_addr, c_wdata, e_addr, e_wdata;
  wire  [N-1:0]       c_ack, e_ack, mem_en, mem_we, busy;
  wire  [N-1:0][31:0] c_rdata, e_rdata, mem_addr, mem_wdata;

  exp_t        sb[$];
  logic [31:0] sh_c [N];
  logic [31:0] sh_e [N];
  int          nchk = 0;
  int          npass = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < N; k++) begin : g_inst
    localparam int L = (k == 0) ? 2 : ((k == 1) ? 1 : 15);
    logic [31:0] mem [256];
    logic [31:0] pd [L];
    logic        pv [L];
    logic [31:0] mem_rdata;

    initial begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hC0FF_EE00 | 32'(i);
      mem[16] <= 32'hDEAD_BEEF;
      for (int j = 0; j < L; j++) pv[j] <= 1'b0;
    end

    // Fixed-latency memory: data read in the mem_en cycle appears L cycles later.
    always @(posedge clk) begin
      if (mem_en[k] && mem_we[k]) mem[mem_addr[k][7:0]] <= mem_wdata[k];
      pv[0] <= mem_en[k] && !mem_we[k];
      pd[0] <= mem[mem_addr[k][7:0]];
      for (int j = 1; j < L; j++) begin
        pv[j] <= pv[j-1];
        pd[j] <= pd[j-1];
      end
    end

    assign mem_rdata = pv[L-1] ? pd[L-1] : 32'hBAD0_BAD0;

    mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(L)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .c_req     (c_req[k]),
      .c_we      (c_we[k]),
      .c_addr    (c_addr[k]),
      .c_wdata   (c_wdata[k]),
      .c_ack     (c_ack[k]),
      .c_rdata   (c_rdata[k]),
      .e_req     (e_req[k]),
      .e_we      (e_we[k]),
      .e_addr    (e_addr[k]),
      .e_wdata   (e_wdata[k]),
      .e_ack     (e_ack[k]),
      .e_rdata   (e_rdata[k]),
      .mem_en    (mem_en[k]),
      .mem_we    (mem_we[k]),
      .mem_addr  (mem_addr[k]),
      .mem_wdata (mem_wdata[k]),
      .mem_rdata (mem_rdata),
      .busy      (busy[k])
    );
  end

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : ((k == 1) ? 1 : 15);
  endfunction

  function automatic logic ack_of(input int k, input logic p);
    return p ? e_ack[k] : c_ack[k];
  endfunction

  function automatic logic [31:0] rdata_of(input int k, input logic p);
    return p ? e_rdata[k] : c_rdata[k];
  endfunction

  function automatic logic [31:0] shadow_of(input int k, input logic p);
    return p ? sh_e[k] : sh_c[k];
  endfunction

  task automatic set_shadow(input int k, input logic p, input logic [31:0] v);
    if (p) sh_e[k] = v;
    else   sh_c[k] = v;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic drive(input int k, input logic p, input logic req, input logic we,
                       input logic [31:0] a, input logic [31:0] d);
    if (!p) begin
      c_req[k] = req; c_we[k] = we; c_addr[k] = a; c_wdata[k] = d;
    end else begin
      e_req[k] = req; e_we[k] = we; e_addr[k] = a; e_wdata[k] = d;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    c_req = '0; c_we = '0; c_addr = '0; c_wdata = '0;
    e_req = '0; e_we = '0; e_addr = '0; e_wdata = '0;
    for (int k = 0; k < N; k++) begin
      sh_c[k] = '0;
      sh_e[k] = '0;
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  // Called at a negedge; 'pre' counts idle cycles before the IDLE sample cycle.
  task automatic run_txn(input int k, input logic p, input logic we, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] rd_exp, input int pre,
                         input bit hold, input string tag);
    exp_t e;
    int   n = 0, ens = 0, en_cyc = -1;
    bit   got = 0, other = 0;
    e.port  = p;
    e.rdata = we ? shadow_of(k, p) : rd_exp;
    e.cyc   = pre + (we ? 2 : lat_of(k) + 2);
    sb.push_back(e);
    drive(k, p, 1'b1, we, a, d);
    while (!got && n < 100) begin
      @(negedge clk);
      n++;
      if (mem_en[k]) begin
        ens++;
        if (en_cyc < 0) begin
          en_cyc = n;
          check({tag, "_mem_we"}, 32'(mem_we[k]), 32'(we));
          check({tag, "_mem_addr"}, mem_addr[k], a);
          if (we) check({tag, "_mem_wdata"}, mem_wdata[k], d);
        end
      end
      if (ack_of(k, !p)) other = 1;
      if (ack_of(k, p)) got = 1;
    end
    check({tag, "_ack_seen"}, 32'(got), 32'd1);
    e = sb.pop_front();
    check({tag, "_ack_cycle"}, 32'(n), 32'(e.cyc));
    check({tag, "_en_cycle"}, 32'(en_cyc), 32'(pre + 1));
    check({tag, "_en_count"}, 32'(ens), 32'd1);
    check({tag, "_rdata"}, rdata_of(k, p), e.rdata);
    check({tag, "_other_rdata"}, rdata_of(k, !p), shadow_of(k, !p));
    check({tag, "_other_ack"}, 32'(other), 32'd0);
    set_shadow(k, p, e.rdata);
    if (!hold) drive(k, p, 1'b0, 1'b0, '0, '0);
  endtask

  // Both ports issue reads and hold them; grants must alternate starting with C.
  task automatic run_both(input int k, input logic [31:0] ca, input logic [31:0] ea,
                          input logic [31:0] c_exp, input logic [31:0] e_exp,
                          input int nacks, input string tag);
    exp_t e;
    int   n = 0, seen = 0, overlap = 0;
    int   l = lat_of(k);
    for (int i = 0; i < nacks; i++) begin
      e.port  = i[0];
      e.rdata = i[0] ? e_exp : c_exp;
      e.cyc   = (l + 2) + i * (l + 3);
      sb.push_back(e);
    end
    drive(k, 1'b0, 1'b1, 1'b0, ca, '0);
    drive(k, 1'b1, 1'b1, 1'b0, ea, '0);
    while (seen < nacks && n < 400) begin
      @(negedge clk);
      n++;
      if (c_ack[k] && e_ack[k]) overlap++;
      if (c_ack[k] || e_ack[k]) begin
        e = sb.pop_front();
        check($sformatf("%s_port%0d", tag, seen), 32'(e_ack[k]), 32'(e.port));
        check($sformatf("%s_cycle%0d", tag, seen), 32'(n), 32'(e.cyc));
        check($sformatf("%s_rdata%0d", tag, seen), rdata_of(k, e_ack[k]), e.rdata);
        set_shadow(k, e.port, e.rdata);
        seen++;
      end
    end
    check({tag, "_acks"}, 32'(seen), 32'(nacks));
    check({tag, "_overlap"}, 32'(overlap), 32'd0);
    drive(k, 1'b0, 1'b0, 1'b0, '0, '0);
    drive(k, 1'b1, 1'b0, 1'b0, '0, '0);
    sb.delete();
  endtask

  initial begin
    bit seen_ack;

    // Reset state of every instance.
    do_reset();
    for (int k = 0; k < N; k++) begin
      check($sformatf("rst%0d_outs", k),
            {26'd0, c_ack[k], e_ack[k], mem_en[k], mem_we[k], busy[k], 1'b0}, 32'd0);
      check($sformatf("rst%0d_bus", k), mem_addr[k] | mem_wdata[k], 32'd0);
      check($sformatf("rst%0d_rdata", k), c_rdata[k] | e_rdata[k], 32'd0);
    end

    // Port C read, then port E write that must leave c_rdata alone.
    run_txn(0, 1'b0, 1'b0, 32'h10, '0, 32'hDEAD_BEEF, 0, 1'b0, "t1_c_read");
    @(negedge clk);
    run_txn(0, 1'b1, 1'b1, 32'h20, 32'h1234_5678, '0, 0, 1'b0, "t2_e_write");
    check("t2_mem_word", g_inst[0].mem[32], 32'h1234_5678);

    // Contention from reset: C, E, C, E.
    do_reset();
    run_both(0, 32'h10, 32'h30, 32'hDEAD_BEEF, 32'hC0FF_EE30, 4, "t3");

    // Write-then-read across the latency sweep.
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      run_txn(k, 1'b1, 1'b1, 32'h40, 32'hA5A5_A5A5, '0, 0, 1'b0, $sformatf("t4_%0d_wr", k));
      @(negedge clk);
      run_txn(k, 1'b0, 1'b0, 32'h40, '0, 32'hA5A5_A5A5, 0, 1'b0, $sformatf("t4_%0d_rd", k));
    end

    // Back-to-back C request raised straight after its ack.
    @(negedge clk);
    run_txn(0, 1'b0, 1'b0, 32'h10, '0, 32'hDEAD_BEEF, 0, 1'b1, "t6_first");
    run_txn(0, 1'b0, 1'b0, 32'h40, '0, 32'hA5A5_A5A5, 1, 1'b0, "t6_second");

    // Reset during ISSUE drops mem_en asynchronously.
    @(negedge clk);
    drive(0, 1'b0, 1'b1, 1'b0, 32'h10, '0);
    @(negedge clk);
    check("t5_issue_en_pre", 32'(mem_en[0]), 32'd1);
    reset = 1'b1;
    #1;
    check("t5_issue_en_async", 32'(mem_en[0]), 32'd0);
    do_reset();

    // Reset during WAIT abandons the read without an ack.
    drive(0, 1'b0, 1'b1, 1'b0, 32'h10, '0);
    repeat (2) @(negedge clk);
    check("t5_wait_busy_pre", 32'(busy[0]), 32'd1);
    reset = 1'b1;
    #1;
    check("t5_wait_busy_async", 32'(busy[0]), 32'd0);
    check("t5_wait_en_async", 32'(mem_en[0]), 32'd0);
    drive(0, 1'b0, 1'b0, 1'b0, '0, '0);
    seen_ack = 0;
    repeat (3) begin
      @(negedge clk);
      if (c_ack[0]) seen_ack = 1;
    end
    check("t5_no_ack", 32'(seen_ack), 32'd0);
    check("t5_rdata_cleared", c_rdata[0], 32'd0);
    reset = 1'b0;
    @(negedge clk);
    run_both(0, 32'h10, 32'h40, 32'hDEAD_BEEF, 32'hA5A5_A5A5, 2, "t5_after");

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "bench time limit reached");
  end

endmodule
